// File: rtl/inc_stream_checker_pkg.sv
// Shared types and constants for the increment-stream checker and its producer-side bench.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents:
//   state_t      - checker state encoding; 2'd3 is unused and treated as IDLE
//   DEF_LOCK_CNT - default consecutive good increments needed to lock
//   DEF_LOSS_CNT - default consecutive misses (while locked) that drop lock
//   cnt_bits()   - width needed to hold the values 0..max_val
package inc_stream_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEEK = 2'd1,
        ST_LOCK = 2'd2
    } state_t;

    localparam int DEF_LOCK_CNT = 4;
    localparam int DEF_LOSS_CNT = 3;

    // Smallest width able to represent max_val itself (not just max_val-1).
    function automatic int cnt_bits(input int max_val);
        int w;
        w = $clog2(max_val + 1);
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/inc_stream_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; clear and increment on one edge yields 1.
// Latency: 1 cycle from INC_I/CLR_I to CNT_O.
// Backpressure: none; an increment at all-ones is absorbed (count holds, never wraps).
//
// Ports:
//   CLK_I  - clock, rising edge
//   RST_I  - synchronous active-high reset, overrides everything
//   CLR_I  - synchronous clear of the count
//   INC_I  - count one event this cycle
//   CNT_O  - registered count, saturates at all-ones
module sat_counter #(
    parameter int P_WIDTH = 16
) (
    input  logic               CLK_I,
    input  logic               RST_I,
    input  logic               CLR_I,
    input  logic               INC_I,
    output logic [P_WIDTH-1:0] CNT_O
);

    localparam logic [P_WIDTH-1:0] CNT_ONE = P_WIDTH'(1);
    localparam logic [P_WIDTH-1:0] CNT_MAX = '1;

    logic [P_WIDTH-1:0] cnt_q;

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            cnt_q <= '0;
        end else if (CLR_I) begin
            // An event landing on the clear edge must not be lost.
            cnt_q <= INC_I ? CNT_ONE : '0;
        end else if (INC_I && (cnt_q != CNT_MAX)) begin
            cnt_q <= cnt_q + CNT_ONE;
        end
    end

    assign CNT_O = cnt_q;

endmodule

// File: rtl/inc_stream_checker.sv
// Checks that each valid sample equals the previous sample plus one (mod 2^P_WIDTH); locks, flywheels, counts errors.
// Latency: 1 cycle; every output is registered and reflects the sample consumed at the previous edge.
// Backpressure: none; a sample is consumed on every edge with VALID_I high, VALID_I low freezes all state.
//
// Ports:
//   CLK_I     - sole clock, rising edge
//   RST_I     - synchronous active-high reset, overrides all other inputs
//   DATA_I    - stream sample
//   VALID_I   - DATA_I qualifier
//   CLR_I     - synchronous clear of ERR_CNT_O only
//   LOCKED_O  - high while locked onto the sequence
//   ERR_O     - one-cycle pulse per mismatch detected while locked
//   EXP_O     - value expected on the next valid sample
//   ERR_CNT_O - saturating count of mismatches detected while locked
module inc_stream_checker
    import inc_stream_checker_pkg::*;
#(
    parameter int P_WIDTH     = 8,
    parameter int P_LOCK_CNT  = DEF_LOCK_CNT,
    parameter int P_LOSS_CNT  = DEF_LOSS_CNT,
    parameter int P_CNT_WIDTH = 16
) (
    input  logic                   CLK_I,
    input  logic                   RST_I,
    input  logic [P_WIDTH-1:0]     DATA_I,
    input  logic                   VALID_I,
    input  logic                   CLR_I,
    output logic                   LOCKED_O,
    output logic                   ERR_O,
    output logic [P_WIDTH-1:0]     EXP_O,
    output logic [P_CNT_WIDTH-1:0] ERR_CNT_O
);

    // Good counter must reach P_LOCK_CNT, miss counter must reach P_LOSS_CNT.
    localparam int GOOD_W = cnt_bits(P_LOCK_CNT);
    localparam int MISS_W = cnt_bits(P_LOSS_CNT);

    localparam logic [P_WIDTH-1:0] DATA_ONE  = P_WIDTH'(1);
    localparam logic [GOOD_W-1:0]  GOOD_ONE  = GOOD_W'(1);
    localparam logic [MISS_W-1:0]  MISS_ONE  = MISS_W'(1);
    localparam logic [GOOD_W-1:0]  LOCK_TGT  = GOOD_W'(P_LOCK_CNT);
    localparam logic [MISS_W-1:0]  LOSS_TGT  = MISS_W'(P_LOSS_CNT);

    state_t              state_q, state_d;
    logic [P_WIDTH-1:0]  exp_q, exp_d;
    logic [GOOD_W-1:0]   good_q, good_d;
    logic [MISS_W-1:0]   miss_q, miss_d;
    logic                err_q, err_d;
    logic                cnt_inc;

    logic                match;
    logic [P_WIDTH-1:0]  data_inc;
    logic [P_WIDTH-1:0]  exp_inc;
    logic [GOOD_W-1:0]   good_inc;
    logic [MISS_W-1:0]   miss_inc;

    // Natural wrap of the adders gives the modulo-2^P_WIDTH rule (FF -> 00 matches).
    assign match    = (DATA_I == exp_q);
    assign data_inc = DATA_I + DATA_ONE;
    assign exp_inc  = exp_q + DATA_ONE;
    assign good_inc = good_q + GOOD_ONE;
    assign miss_inc = miss_q + MISS_ONE;

    // ------------------------------------------------------------------
    // Next-state / next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        exp_d   = exp_q;
        good_d  = good_q;
        miss_d  = miss_q;
        err_d   = 1'b0;
        cnt_inc = 1'b0;

        if (VALID_I) begin
            case (state_q)
                ST_SEEK: begin
                    // Mismatches while seeking simply re-anchor on the new sample.
                    exp_d = data_inc;
                    if (match) begin
                        good_d = good_inc;
                        if (good_inc == LOCK_TGT) begin
                            state_d = ST_LOCK;
                            miss_d  = '0;
                        end
                    end else begin
                        good_d = '0;
                    end
                end

                ST_LOCK: begin
                    if (match) begin
                        miss_d = '0;
                        exp_d  = data_inc;
                    end else begin
                        err_d   = 1'b1;
                        cnt_inc = 1'b1;
                        miss_d  = miss_inc;
                        if (miss_inc == LOSS_TGT) begin
                            // Too many in a row: the stream has moved, re-anchor on it.
                            state_d = ST_SEEK;
                            good_d  = '0;
                            miss_d  = '0;
                            exp_d   = data_inc;
                        end else begin
                            // Flywheel: assume a corrupted sample, keep counting.
                            exp_d = exp_inc;
                        end
                    end
                end

                // ST_IDLE and the unused encoding: first sample becomes the reference.
                default: begin
                    state_d = ST_SEEK;
                    exp_d   = data_inc;
                    good_d  = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state_q <= ST_IDLE;
            exp_q   <= '0;
            good_q  <= '0;
            miss_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            exp_q   <= exp_d;
            good_q  <= good_d;
            miss_q  <= miss_d;
            err_q   <= err_d;
        end
    end

    sat_counter #(
        .P_WIDTH (P_CNT_WIDTH)
    ) u_err_cnt (
        .CLK_I (CLK_I),
        .RST_I (RST_I),
        .CLR_I (CLR_I),
        .INC_I (cnt_inc),
        .CNT_O (ERR_CNT_O)
    );

    // state_q is a register, so the decode is glitch-free and still one cycle after the sample.
    assign LOCKED_O = (state_q == ST_LOCK);
    assign ERR_O    = err_q;
    assign EXP_O    = exp_q;

endmodule

// File: doc/inc_stream_checker.md
Name: inc_stream_checker

Overview:
Receive-side partner of the increment data producer: consumes the registered byte stream and checks that each valid sample equals the previous sample plus one, modulo 2^P_WIDTH.
Locks onto the sequence, flywheels through isolated errors, and declares loss after repeated mismatches.
Reports lock status, a per-error pulse, the next expected value and a saturating error count.
Sits directly after the producer, in the CLK_I domain, as an in-system integrity monitor.

Parameters:
P_WIDTH, 8, data width; increment arithmetic is modulo 2^P_WIDTH
P_LOCK_CNT, 4, consecutive correct increments needed to declare lock (min 1)
P_LOSS_CNT, 3, consecutive mismatches while locked that cause loss of lock (min 1)
P_CNT_WIDTH, 16, error counter width

Ports:
CLK_I  in  1  sole clock; all logic on rising edge
RST_I  in  1  synchronous reset, active-high
DATA_I  in  P_WIDTH  stream sample, sync CLK_I
VALID_I  in  1  DATA_I qualifier; sample consumed when high at a rising edge
CLR_I  in  1  synchronous clear of ERR_CNT_O only
LOCKED_O  out  1  high while in LOCK
ERR_O  out  1  one-cycle pulse per mismatch detected in LOCK
EXP_O  out  P_WIDTH  value expected on the next valid sample
ERR_CNT_O  out  P_CNT_WIDTH  saturating mismatch count

Behaviour:
- Interface (decided): one clock, CLK_I; reset RST_I is synchronous and active-high. RST_I overrides every other input.
- Reset values: state IDLE; LOCKED_O=0, ERR_O=0, EXP_O=0, ERR_CNT_O=0; internal good/miss counters 0.
- All outputs are registered. The effect of a valid sample at edge N is visible after edge N (1-cycle latency).
- VALID_I low: state, EXP_O and counters hold; ERR_O=0.
- Match rule: DATA_I == EXP_O. EXP_O always updates to sample+1 mod 2^P_WIDTH, except in the LOCK flywheel case below. 8'hFF followed by 8'h00 is a match.
- IDLE: first valid sample sets EXP_O=DATA_I+1; good=0; next state SEEK. No error is flagged.
- SEEK, match: good++. When good reaches P_LOCK_CNT, go to LOCK with miss=0.
- SEEK, mismatch: resync with EXP_O=DATA_I+1 and good=0; stay in SEEK. No ERR_O and no count.
- LOCK, match: miss=0; EXP_O=DATA_I+1.
- LOCK, mismatch: ERR_O pulses; ERR_CNT_O increments; miss++.
  - Flywheel: EXP_O=EXP_O+1, ignoring the bad data.
  - If miss reaches P_LOSS_CNT: go to SEEK with good=0, EXP_O=DATA_I+1, LOCKED_O falls on the same edge. ERR_O still pulses for this sample.
- ERR_CNT_O saturates at all-ones and never wraps.
- CLR_I clears ERR_CNT_O and nothing else. If CLR_I and a counted error occur on the same edge, ERR_CNT_O=1.
- RST_I asserted mid-lock: next edge returns to IDLE. The first valid sample after reset is treated as a fresh reference.

Decomposition:
- Shared header inc_stream_pkg.vh holds:
  - state encodings ST_IDLE=2'd0, ST_SEEK=2'd1, ST_LOCK=2'd2 (2'd3 unused and decodes to IDLE);
  - default P_LOCK_CNT and P_LOSS_CNT constants for reuse by the producer-side bench.
- One natural sub-module: sat_counter (parameter width; synchronous clr, inc, saturation), used for ERR_CNT_O.
- Good/miss counters stay inline.

Test Plan:
- Lock and wrap: reset, then VALID_I=1 with data 8'hFC,FD,FE,FF,00,01 -> LOCKED_O=1 after the 5th sample's edge; no ERR_O; EXP_O=8'h02 at the end.
- Isolated glitch: locked at 8'h10, send 11,55,13,14 -> one ERR_O pulse on the 55 sample; ERR_CNT_O=1; LOCKED_O stays 1; EXP_O=8'h15.
- Loss of lock: locked, send 3 consecutive wrong values 8'h80,90,A0 -> 3 ERR_O pulses; LOCKED_O falls on the 3rd; EXP_O=8'hA1; relocks after 4 further correct increments.
- VALID gaps: locked sequence 20,(VALID_I=0 for 5 cycles with DATA_I=8'h77),21 -> no error; state and EXP_O held.
- Saturation and clear: P_CNT_WIDTH=2, locked, inject errors spaced by matches -> ERR_CNT_O goes 1,2,3,3; CLR_I coincident with the next error -> ERR_CNT_O=1.
- Reset mid-lock: RST_I high for 1 cycle while locked -> all outputs 0 on the next edge; the next sample 8'h42 gives EXP_O=8'h43 and state SEEK, with no ERR_O.
